// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag field layout, command/target codes and responder states.
package sysbus_pkg;

   localparam int TAG_RW_BIT  = 12;
   localparam int TAG_TGT_MSB = 11;
   localparam int TAG_TGT_LSB = 8;

   localparam logic       SYSBUS_READ   = 1'b1;
   localparam logic       SYSBUS_WRITE  = 1'b0;
   localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

   localparam int SYSBUS_BURST_LEN = 8;

   typedef enum logic [1:0] {
      IDLE,
      WR_DATA,
      RD_ISSUE,
      RD_DRAIN
   } resp_state_t;

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response channel between the core-side initiator and a memory target.
interface sysbus_mem_responder_if #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13
) ();

   logic                      bus_reqcyc;
   logic                      bus_reqack;
   logic [BUS_DATA_WIDTH-1:0] bus_req;
   logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
   logic                      bus_respcyc;
   logic                      bus_respack;
   logic [BUS_DATA_WIDTH-1:0] bus_resp;
   logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

   modport master (
      output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
      input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
   );

   modport slave (
      input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
      output bus_reqack, bus_respcyc, bus_resp, bus_resptag
   );

endinterface

// File: rtl/sysbus_resp_fifo.sv
// Small synchronous FIFO holding read beats between the RAM and the response channel.
module sysbus_resp_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic [CNT_W-1:0] o_count,
   output logic             o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus target: services line-sized read/write bursts against a 1-cycle-latency word RAM.
module sysbus_mem_responder
   import sysbus_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int BURST_LEN      = SYSBUS_BURST_LEN,
   parameter int MEM_ADDR_WIDTH = 16,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   sysbus_mem_responder_if.slave     bus,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic                      mem_rd,
   output logic                      mem_wr,
   output logic [BUS_DATA_WIDTH-1:0] mem_wdata,
   input  logic [BUS_DATA_WIDTH-1:0] mem_rdata
);

   localparam int BEAT_W = $clog2(BURST_LEN);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

   resp_state_t               r_state;
   resp_state_t               w_state_nxt;
   logic [BUS_TAG_WIDTH-1:0]  r_tag;
   logic [MEM_ADDR_WIDTH-1:0] r_base;
   logic [BEAT_W-1:0]         r_cnt;
   logic [BEAT_W-1:0]         r_pop_cnt;
   logic                      r_inflight;

   logic                      w_reqack;
   logic                      w_req_acc;
   logic                      w_pop;
   logic                      w_mem_rd;
   logic                      w_tgt_mem;
   logic                      w_issue_ok;
   logic                      w_fifo_empty;
   logic [CNT_W-1:0]          w_fifo_count;
   logic [CNT_W:0]            w_occ;
   logic [BUS_DATA_WIDTH-1:0] w_head;
   logic [MEM_ADDR_WIDTH-1:0] w_line;
   logic [BEAT_W-1:0]         w_last;

   assign w_req_acc = bus.bus_reqcyc && w_reqack;
   assign w_pop     = bus.bus_respcyc && bus.bus_respack;
   assign w_tgt_mem = (bus.bus_reqtag[TAG_TGT_MSB:TAG_TGT_LSB] == SYSBUS_MEMORY);
   assign w_line    = {bus.bus_req[MEM_ADDR_WIDTH+2:3+BEAT_W], BEAT_W'(0)};
   assign w_last    = BEAT_W'(BURST_LEN - 1);

   // Occupancy the FIFO will have once every issued read has landed; issuing only
   // below FIFO_DEPTH means a beat always has a slot when it returns.
   assign w_occ      = (CNT_W+1)'(w_fifo_count) + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
   assign w_issue_ok = (w_occ < (CNT_W+1)'(FIFO_DEPTH));

   always_comb begin
      w_state_nxt = r_state;
      w_reqack    = 1'b0;
      w_mem_rd    = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      if (!reset) begin
         case (r_state)
            IDLE: begin
               w_reqack = bus.bus_reqcyc;
               if (bus.bus_reqcyc && w_tgt_mem)
                  w_state_nxt = (bus.bus_reqtag[TAG_RW_BIT] == SYSBUS_WRITE) ? WR_DATA : RD_ISSUE;
            end
            WR_DATA: begin
               w_reqack = bus.bus_reqcyc;
               mem_addr = r_base + MEM_ADDR_WIDTH'(r_cnt);
               if (bus.bus_reqcyc) begin
                  mem_wr    = 1'b1;
                  mem_wdata = bus.bus_req;
                  if (r_cnt == w_last) w_state_nxt = IDLE;
               end
            end
            RD_ISSUE: begin
               mem_addr = r_base + MEM_ADDR_WIDTH'(r_cnt);
               if (w_issue_ok) begin
                  w_mem_rd = 1'b1;
                  if (r_cnt == w_last) w_state_nxt = RD_DRAIN;
               end
            end
            RD_DRAIN: begin
               if (w_pop && (r_pop_cnt == w_last)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_tag      <= '0;
         r_base     <= '0;
         r_cnt      <= '0;
         r_pop_cnt  <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_mem_rd;
         if ((r_state == IDLE) && w_req_acc && w_tgt_mem) begin
            r_tag     <= bus.bus_reqtag;
            r_base    <= w_line;
            r_cnt     <= '0;
            r_pop_cnt <= '0;
         end else begin
            if (mem_wr || w_mem_rd) r_cnt <= r_cnt + 1'b1;
            if (w_pop)              r_pop_cnt <= r_pop_cnt + 1'b1;
         end
      end
   end

   sysbus_resp_fifo #(
      .WIDTH (BUS_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (r_inflight),
      .i_data  (mem_rdata),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty)
   );

   assign mem_rd          = w_mem_rd;
   assign bus.bus_reqack  = w_reqack;
   assign bus.bus_respcyc = !w_fifo_empty;
   assign bus.bus_resp    = w_fifo_empty ? '0 : w_head;
   assign bus.bus_resptag = r_tag;

endmodule
